// File: rtl/alu_pkg.sv
// Shared types for the ALU front-end: operation encodings, request layout and
// result-stage states.
package alu_pkg;

  localparam int unsigned OPND_W = 2;
  localparam int unsigned RES_W  = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    alu_op_e           op;
  } alu_req_t;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_HOLD   = 2'b01,
    ST_STREAM = 2'b10
  } res_state_e;

  // The ALU reports divide-by-zero through its carry flag on a DIV.
  function automatic logic is_div_err(alu_op_e op, logic c);
    return (op == OP_DIV) && c;
  endfunction

endpackage

// File: rtl/op_fifo.sv
// DEPTH-deep request FIFO with occupancy count and an always-visible head entry.
module op_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  alu_req_t                 data_i,
  input  logic                     pop_i,
  output alu_req_t                 head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  alu_req_t         mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequential front-end for simple_alu: buffers requests, drives the ALU from the
// FIFO head and registers its result behind a valid/ready output stage.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_a,
  input  logic [1:0]             in_b,
  input  logic [1:0]             in_op,
  output logic [1:0]             alu_a,
  output logic [1:0]             alu_b,
  output logic [1:0]             alu_ctrl,
  input  logic [3:0]             alu_y,
  input  logic                   alu_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_y,
  output logic                   out_c,
  output logic [1:0]             out_op,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       op_cnt,
  output logic [CNT_W-1:0]       err_cnt
);

  alu_req_t   req, head;
  logic       fifo_full, fifo_empty, push, pop, out_hs;
  res_state_e state_q, state_d;
  logic [3:0] y_q;
  logic       c_q;
  alu_op_e    op_q;
  logic [CNT_W-1:0] op_cnt_q, err_cnt_q;

  assign req      = '{a: in_a, b: in_b, op: alu_op_e'(in_op)};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (req),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign alu_a    = fifo_empty ? '0 : head.a;
  assign alu_b    = fifo_empty ? '0 : head.b;
  assign alu_ctrl = fifo_empty ? '0 : head.op;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_hs    = out_valid && out_ready;
  assign pop       = !fifo_empty && (!out_valid || out_ready);

  // STREAM marks a result loaded in the same cycle the previous one was taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY:          if (pop) state_d = ST_HOLD;
      ST_HOLD, ST_STREAM: begin
        if (out_ready) state_d = pop ? ST_STREAM : ST_EMPTY;
        else           state_d = ST_HOLD;
      end
      default:           state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      y_q       <= '0;
      c_q       <= 1'b0;
      op_q      <= OP_ADD;
      op_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        y_q  <= alu_y;
        c_q  <= alu_c;
        op_q <= head.op;
      end
      if (out_hs) begin
        if (op_cnt_q != '1)             op_cnt_q  <= op_cnt_q + 1'b1;
        if (out_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign out_y   = y_q;
  assign out_c   = c_q;
  assign out_op  = op_q;
  assign out_err = is_div_err(op_q, c_q);
  assign op_cnt  = op_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural simple_alu on the ALU port.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [1:0] in_a, in_b, in_op;
  logic [1:0] alu_a, alu_b, alu_ctrl;
  logic [3:0] alu_y;
  logic       alu_c;
  logic       out_valid, out_ready;
  logic [3:0] out_y;
  logic       out_c;
  logic [1:0] out_op;
  logic       out_err;
  logic [2:0] fifo_count;
  logic [7:0] op_cnt, err_cnt;

  int errors = 0;
  int checks = 0;
  int exp_ops = 0;
  int exp_errs = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_c(out_c), .out_op(out_op), .out_err(out_err),
    .fifo_count(fifo_count), .op_cnt(op_cnt), .err_cnt(err_cnt)
  );

  // simple_alu behaviour: add, sub with borrow, mul, div with div0 flag.
  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    case (alu_ctrl)
      2'b00: alu_y = {2'b00, alu_a} + {2'b00, alu_b};
      2'b01: begin alu_y = {2'b00, alu_a} - {2'b00, alu_b}; alu_c = (alu_a < alu_b); end
      2'b10: alu_y = {2'b00, alu_a} * {2'b00, alu_b};
      default: begin
        if (alu_b == 2'b00) alu_c = 1'b1;
        else alu_y = {2'b00, alu_a / alu_b};
      end
    endcase
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic test_reset_state();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || fifo_count !== 3'd0 ||
        alu_ctrl !== 2'b00 || op_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b fifo_count=%0d alu_ctrl=%b op_cnt=%0d err_cnt=%0d, required 0 1 0 00 0 0",
               out_valid, in_ready, fifo_count, alu_ctrl, op_cnt, err_cnt);
    end
  endtask

  typedef struct {
    logic [1:0] a, b, op;
    logic [3:0] y;
    logic       c, err;
  } vec_t;

  task automatic test_arith();
    vec_t tbl [5];
    tbl = '{'{2'd3, 2'd2, 2'b00, 4'd5,  1'b0, 1'b0},
            '{2'd1, 2'd2, 2'b01, 4'hF,  1'b1, 1'b0},
            '{2'd3, 2'd0, 2'b11, 4'd0,  1'b1, 1'b1},
            '{2'd3, 2'd1, 2'b11, 4'd3,  1'b0, 1'b0},
            '{2'd2, 2'd3, 2'b10, 4'd6,  1'b0, 1'b0}};
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      in_a = tbl[i].a; in_b = tbl[i].b; in_op = tbl[i].op; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL arith%0d_latency: out_valid=%b one cycle after accept, required 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_y !== tbl[i].y || out_c !== tbl[i].c ||
          out_err !== tbl[i].err || out_op !== tbl[i].op) begin
        errors++;
        $display("FAIL arith%0d_result: valid=%b y=%h c=%b err=%b op=%b, required 1 %h %b %b %b",
                 i, out_valid, out_y, out_c, out_err, out_op, tbl[i].y, tbl[i].c, tbl[i].err, tbl[i].op);
      end
      @(negedge clk);
      exp_ops++;
      if (tbl[i].err) exp_errs++;
      checks++;
      if (op_cnt !== 8'(exp_ops) || err_cnt !== 8'(exp_errs) || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL arith%0d_counters: op_cnt=%0d err_cnt=%0d out_valid=%b, required %0d %0d 0",
                 i, op_cnt, err_cnt, out_valid, exp_ops, exp_errs);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] av [6];
    logic [1:0] bv [6];
    int idx = 0;
    logic acc;
    av = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    bv = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_a = av[idx]; in_b = bv[idx]; in_op = 2'b00; in_valid = 1'b1;
      acc = in_ready;
      @(negedge clk);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 5 || in_ready !== 1'b0 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL bp_full: accepted=%0d in_ready=%b fifo_count=%0d, required 5 0 4", idx, in_ready, fifo_count);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_y !== 4'd1 || out_op !== 2'b00 || fifo_count !== 3'd4) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b y=%0d op=%b count=%0d, required 1 1 00 4", k, out_valid, out_y, out_op, fifo_count);
      end
    end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_y !== 4'(j + 1)) begin
        errors++;
        $display("FAIL bp_drain%0d: valid=%b y=%0d, required 1 %0d", j, out_valid, out_y, j + 1);
      end
      @(negedge clk);
    end
    exp_ops += 5;
    checks++;
    if (out_valid !== 1'b0 || op_cnt !== 8'(exp_ops) || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL bp_after: valid=%b op_cnt=%0d count=%0d, required 0 %0d 0", out_valid, op_cnt, fifo_count, exp_ops);
    end
  endtask

  task automatic test_back_to_back();
    int issued = 0, seen = 0, first = -1, last = -1;
    logic [2:0] maxcnt = '0;
    out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (fifo_count > maxcnt) maxcnt = fifo_count;
      if (out_valid) begin
        seen++;
        if (first < 0) first = t;
        last = t;
        checks++;
        if (out_y !== 4'd9) begin
          errors++;
          $display("FAIL stream_y_t%0d: out_y=%0d, required 9", t, out_y);
        end
      end
      in_a = 2'd3; in_b = 2'd3; in_op = 2'b10;
      in_valid = (issued < 8);
      if (in_valid && in_ready) issued++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    exp_ops += 8;
    checks++;
    if (seen != 8 || first != 2 || last != 9 || maxcnt > 3'd1 || op_cnt !== 8'(exp_ops)) begin
      errors++;
      $display("FAIL stream: seen=%0d first=%0d last=%0d maxcount=%0d op_cnt=%0d, required 8 2 9 <=1 %0d",
               seen, first, last, maxcnt, op_cnt, exp_ops);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    in_a = 2'd3; in_b = 2'd0; in_op = 2'b11; in_valid = 1'b1;
    repeat (300) @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (op_cnt !== 8'd255 || err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL saturation: op_cnt=%0d err_cnt=%0d, required 255 255", op_cnt, err_cnt);
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    in_a = 2'd3; in_b = 2'd1; in_op = 2'b11; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd2 || out_valid !== 1'b1 || alu_ctrl !== 2'b11) begin
      errors++;
      $display("FAIL reset_pre: count=%0d valid=%b alu_ctrl=%b, required 2 1 11", fifo_count, out_valid, alu_ctrl);
    end
    #2 rst = 1'b1;
    #1 test_reset_state();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || op_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_discard: valid=%b count=%0d op_cnt=%0d, required 0 0 0", out_valid, fifo_count, op_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    #2 test_reset_state();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequential front-end for the team's 2-bit combinational ALU (simple_alu).
- Accepts operation requests {a, b, op} over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drives the FIFO head onto the ALU operand/control lines, then captures the ALU's {y, c} into an output result register with its own valid/ready handshake.
- Keeps saturating counters of completed operations and divide-by-zero errors.

Parameters:
- DEPTH, 4: FIFO entries. Power of two, at least 2.
- CNT_W, 8: width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  FIFO can accept.
- in_a  in  2  operand A.
- in_b  in  2  operand B.
- in_op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- alu_a  out  2  to ALU A.
- alu_b  out  2  to ALU B.
- alu_ctrl  out  2  to ALU ctrl.
- alu_y  in  4  ALU result.
- alu_c  in  1  ALU carry/borrow/div0 flag.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer accepts the result.
- out_y  out  4  registered result.
- out_c  out  1  registered carry/borrow flag.
- out_op  out  2  op that produced the result.
- out_err  out  1  divide by zero: out_op==11 and out_c==1.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- op_cnt  out  CNT_W  completed results (counted on output handshake), saturating.
- err_cnt  out  CNT_W  completed results with out_err=1, saturating.

Behaviour:
- Reset (asynchronous, immediate):
  - FIFO pointers, fifo_count, out_valid, out_y, out_c, out_op, op_cnt and err_cnt all go to 0.
  - in_ready=1 and alu_a/alu_b/alu_ctrl=0.
  - Reset mid-operation discards all buffered and in-flight work.
- Push: in_valid && in_ready. in_ready = (fifo_count < DEPTH), derived from registered state only. A same-cycle pop does not free a slot for a same-cycle push.
- ALU drive:
  - FIFO non-empty: alu_* = head entry, combinationally.
  - FIFO empty: alu_* = 0.
- Pop/load:
  - Condition: fifo non-empty && (!out_valid || out_ready).
  - On the clock edge: out_y <= alu_y, out_c <= alu_c, out_op <= head op, out_valid <= 1, and the head pointer advances.
- Drain: out_valid && out_ready with the FIFO empty clears out_valid.
- Latency and throughput:
  - A request accepted at edge k appears with out_valid=1 after edge k+1 (minimum 2 cycles, no fall-through).
  - Throughput is 1 result per cycle while both handshakes are held high.
- Result-stage FSM:
  - States: EMPTY (out_valid=0), HOLD (out_valid=1, out_ready=0, output stable), STREAM (out_valid=1, out_ready=1).
  - EMPTY->HOLD/STREAM on load.
  - HOLD keeps out_* unchanged regardless of FIFO activity.
  - STREAM->EMPTY when it drains with the FIFO empty.
- Simultaneous push and pop: fifo_count unchanged, pointers both advance.
- Pointers wrap modulo DEPTH. Full/empty are decided by fifo_count.
- Counters:
  - On each output handshake, op_cnt += 1, and err_cnt += 1 if out_err.
  - Both hold at 2^CNT_W-1.
- Arithmetic is entirely in the ALU. This block never alters {y, c}. out_err is purely combinational from the registered out_op/out_c.
- in_valid while full: the request is not accepted. Upstream must hold it.

Decomposition:
- Shared package alu_pkg:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - operand width 2, result width 4, and the request struct {a, b, op}.
- One natural sub-module: op_fifo, a synchronous DEPTH-deep FIFO with count, full/empty and head read port.
- The result register, FSM and counters live in the top level.

Test Plan:
- Reset: assert rst mid-stream with 3 ops buffered -> immediately out_valid=0, fifo_count=0, in_ready=1, alu_ctrl=0, op_cnt=0.
- Add: push a=3, b=2, op=00, out_ready=1 -> two edges later out_valid=1, out_y=5, out_c=0, out_err=0, then op_cnt=1.
- Subtract with borrow: a=1, b=2, op=01 -> out_y=4'hF, out_c=1, out_err=0, err_cnt stays 0.
- Divide by zero: a=3, b=0, op=11 -> out_y=0, out_c=1, out_err=1. After the handshake err_cnt=1. Then a=3, b=1, op=11 -> out_y=3, out_err=0.
- Backpressure with out_ready=0 and a continuous push of ops:
  - Exactly 5 accepted (1 in the result register, 4 in the FIFO), then in_ready=0 and fifo_count=4.
  - The held result is unchanged over 10 cycles.
  - Raising out_ready drains all 5 in order, one per cycle.
- Streaming: 8 back-to-back mul ops a=3, b=3 with both handshakes high -> out_y=9 on every cycle after the 2-cycle fill, fifo_count never exceeds 1, op_cnt=8.
